// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-writer command codes, bit-level codes and the
// write sequencer's state encoding.
package i2c_pkg;

    typedef enum logic [2:0] {
        WR_IDLE  = 3'b000,
        WR_START = 3'b001,
        WR_DATA  = 3'b011,
        WR_STOP  = 3'b100,
        WR_ACK   = 3'b101,
        WR_NACK  = 3'b110
    } wr_cmd_e;

    typedef enum logic [2:0] {
        BIT_IDLE   = 3'b000,
        BIT_START  = 3'b010,
        BIT_STOP   = 3'b011,
        BIT_DATA_0 = 3'b100,
        BIT_DATA_1 = 3'b101,
        BIT_ACK    = 3'b110,
        BIT_NACK   = 3'b111
    } bit_code_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_FETCH    = 4'd4,
        ST_DATA     = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_STOP     = 4'd7,
        ST_DONE     = 4'd8
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_tx_shifter.sv
// 8-bit parallel-load register that shifts left (zero fill) on each consumed
// bit and exposes its MSB as the next bit to transmit.
module i2c_tx_shifter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       shift_i,
    output logic       msb_o
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = load_data_i;
        end else if (shift_i) begin
            shift_d = {shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= 8'h00;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign msb_o = shift_q[7];

endmodule

// File: rtl/i2c_master_write_sequencer.sv
// Transaction-level I2C write sequencer: START, address+W, payload bytes and
// STOP issued as byte-writer commands, with slave ACK checked after each byte.
module i2c_master_write_sequencer
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [6:0] cmd_addr,
    output logic       cmd_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [7:0] ack_count,
    output logic       wr_go,
    output logic [2:0] wr_command,
    output logic       wr_data,
    input  logic       wr_load,
    input  logic       wr_finish,
    output logic       ack_go,
    input  logic       ack_finish,
    input  logic       ack_bit
);

    seq_state_e state_q, state_d;
    wr_cmd_e    wr_cmd_q, wr_cmd_d;
    logic       wr_go_q, wr_go_d;
    logic       ack_go_q, ack_go_d;
    logic       issued_q, issued_d;
    logic       tx_ready_q, tx_ready_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [7:0] count_q, count_d;

    logic       sh_load;
    logic [7:0] sh_din;
    logic       sh_shift;

    always_comb begin
        state_d    = state_q;
        wr_cmd_d   = wr_cmd_q;
        wr_go_d    = wr_go_q;
        ack_go_d   = ack_go_q;
        issued_d   = issued_q;
        tx_ready_d = 1'b0;
        last_d     = last_q;
        err_d      = err_q;
        count_d    = count_q;
        sh_load    = 1'b0;
        sh_din     = tx_data;
        sh_shift   = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && wr_load;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    sh_load = 1'b1;
                    sh_din  = {cmd_addr, 1'b0};
                    err_d   = 1'b0;
                    count_d = 8'h00;
                    last_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            // Go rises one cycle after entry, so it always has a low cycle
            // between consecutive commands.
            ST_START, ST_ADDR, ST_DATA, ST_STOP: begin
                if (!issued_q) begin
                    wr_go_d  = 1'b1;
                    issued_d = 1'b1;
                    wr_cmd_d = (state_q == ST_START) ? WR_START :
                               (state_q == ST_STOP)  ? WR_STOP  : WR_DATA;
                end else if (wr_go_q && wr_finish) begin
                    wr_go_d  = 1'b0;
                    wr_cmd_d = WR_IDLE;
                    if (state_q == ST_START) begin
                        state_d = ST_ADDR;
                    end else if (state_q == ST_ADDR) begin
                        state_d = ST_ADDR_ACK;
                    end else if (state_q == ST_DATA) begin
                        state_d = ST_DATA_ACK;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                if (!issued_q) begin
                    ack_go_d = 1'b1;
                    issued_d = 1'b1;
                end else if (ack_go_q && ack_finish) begin
                    ack_go_d = 1'b0;
                    if (ack_bit) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_FETCH;
                    end else begin
                        count_d = sat_inc8(count_q);
                        state_d = last_q ? ST_STOP : ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (tx_ready_q) begin
                    if (tx_valid) begin
                        sh_load = 1'b1;
                        last_d  = tx_last;
                        state_d = ST_DATA;
                    end
                end else if (tx_valid) begin
                    tx_ready_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            issued_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_cmd_q   <= WR_IDLE;
            wr_go_q    <= 1'b0;
            ack_go_q   <= 1'b0;
            issued_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_cmd_q   <= wr_cmd_d;
            wr_go_q    <= wr_go_d;
            ack_go_q   <= ack_go_d;
            issued_q   <= issued_d;
            tx_ready_q <= tx_ready_d;
            last_q     <= last_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    i2c_tx_shifter u_shifter (
        .clock       (clock),
        .reset       (reset),
        .load_i      (sh_load),
        .load_data_i (sh_din),
        .shift_i     (sh_shift),
        .msb_o       (wr_data)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign nack_err   = err_q;
    assign ack_count  = count_q;
    assign wr_go      = wr_go_q;
    assign wr_command = wr_cmd_q;
    assign ack_go     = ack_go_q;
    assign tx_ready   = tx_ready_q;

endmodule

// File: tb/tb_i2c_master_write_sequencer.sv
// Scoreboard bench for i2c_master_write_sequencer with byte-writer, ACK-reader
// and payload-source models around the DUT.
module tb_i2c_master_write_sequencer;
    import i2c_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_ready;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic [7:0] ack_count;
    logic       wr_go;
    logic [2:0] wr_command;
    logic       wr_data;
    logic       wr_load = 1'b0;
    logic       wr_finish = 1'b0;
    logic       ack_go;
    logic       ack_finish = 1'b0;
    logic       ack_bit = 1'b0;

    i2c_master_write_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .busy(busy), .done(done), .nack_err(nack_err), .ack_count(ack_count),
        .wr_go(wr_go), .wr_command(wr_command), .wr_data(wr_data),
        .wr_load(wr_load), .wr_finish(wr_finish),
        .ack_go(ack_go), .ack_finish(ack_finish), .ack_bit(ack_bit)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_cmd_q[$];   // {command, byte seen on the wire}
    logic [8:0]  exp_done_q[$];  // {nack_err, ack_count}
    logic        ack_plan_q[$];  // ack_bit to return per ACK read
    logic [8:0]  tx_q[$];        // {last, data}

    int         done_seen = 0;
    int         done_target = 0;
    int         acks_done = 0;
    int         flush_req = 0;
    int         reset_req = 0;
    int         reset_ack = 0;
    logic       gate_hold = 1'b0;
    logic       inject_reset = 1'b0;
    logic [8:0] exp_res = 9'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [18:0] outs();
        return {cmd_ready, busy, done, nack_err, ack_count, wr_go, wr_command,
                wr_data, tx_ready, ack_go};
    endfunction

    // Byte-writer model: collects each command and its MSB-first bitstream.
    initial begin : writer_model
        logic [2:0]  cmd;
        logic [7:0]  b;
        logic [10:0] exp;
        int          dcnt;
        bit          aborted;
        bit          merge;
        dcnt = 0;
        forever begin
            @(negedge clock);
            if (wr_go) begin
                cmd = wr_command;
                b = 8'h00;
                aborted = 0;
                merge = 0;
                if (cmd == WR_START) dcnt = 0;
                repeat ($urandom_range(0, 2)) @(negedge clock);
                chk("wr_go_held", {wr_go, wr_command}, {1'b1, cmd});
                if (cmd == WR_DATA) begin
                    merge = ($urandom_range(0, 1) == 1);
                    for (int i = 0; i < 8; i++) begin
                        if (inject_reset && dcnt > 0 && i == 3) begin
                            aborted = 1;
                            break;
                        end
                        repeat ($urandom_range(0, 1)) @(negedge clock);
                        b = {b[6:0], wr_data};
                        wr_load = 1'b1;
                        if (i == 7 && merge) wr_finish = 1'b1;
                        @(negedge clock);
                        wr_load = 1'b0;
                        wr_finish = 1'b0;
                    end
                    dcnt++;
                end else if (cmd == WR_START) begin
                    wr_load = 1'b1;
                    @(negedge clock);
                    wr_load = 1'b0;
                end
                if (aborted) begin
                    reset_req++;
                    while (reset_ack != reset_req) @(negedge clock);
                end else begin
                    if (!(cmd == WR_DATA && merge)) begin
                        wr_finish = 1'b1;
                        @(negedge clock);
                        wr_finish = 1'b0;
                    end
                    chk("wr_go_cleared", {wr_go, wr_command}, 4'b0000);
                    if (exp_cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_cmd_extra: got cmd %0d byte 0x%0h expected none", cmd, b);
                    end else begin
                        exp = exp_cmd_q.pop_front();
                        chk("wr_cmd_byte", {cmd, b}, exp);
                    end
                end
            end
        end
    end

    // ACK-read model: ack_bit is random garbage except while ack_finish is high.
    initial begin : ack_model
        forever begin
            @(negedge clock);
            ack_bit = 1'($urandom_range(0, 1));
            if (ack_go) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                if (ack_plan_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_extra: got ack_go 1 expected 0");
                    ack_bit = 1'b1;
                end else begin
                    ack_bit = ack_plan_q.pop_front();
                end
                ack_finish = 1'b1;
                @(negedge clock);
                ack_finish = 1'b0;
                ack_bit = 1'($urandom_range(0, 1));
                chk("ack_go_cleared", ack_go, 0);
                acks_done++;
            end
        end
    end

    // Payload source: holds valid until accepted, random idle gaps otherwise.
    initial begin : tx_source
        bit acc;
        int flush_seen;
        acc = 0;
        flush_seen = 0;
        forever begin
            @(negedge clock);
            if (flush_seen != flush_req) begin
                flush_seen = flush_req;
                tx_q.delete();
                acc = 0;
                tx_valid = 1'b0;
            end else begin
                if (acc) begin
                    if (tx_q.size() > 0) void'(tx_q.pop_front());
                    acc = 0;
                    tx_valid = 1'b0;
                end
                if (tx_valid && tx_ready) begin
                    acc = 1;
                end else if (!tx_valid && tx_q.size() > 0 && !gate_hold &&
                             $urandom_range(0, 3) != 0) begin
                    tx_valid = 1'b1;
                    {tx_last, tx_data} = tx_q[0];
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clock);
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_extra: got done 1 expected 0");
                end else begin
                    chk("done_result", {nack_err, ack_count}, exp_done_q.pop_front());
                end
                done_seen++;
                @(negedge clock);
                chk("ready_after_done", {cmd_ready, done, busy}, 3'b100);
            end
        end
    end

    initial begin : go_exclusive
        forever begin
            @(negedge clock);
            if (wr_go || ack_go) chk("go_exclusive", wr_go & ack_go, 0);
        end
    end

    task automatic start_txn(input logic [6:0] addr, input logic [7:0] bytes[$],
                             input int nack_at, output int leftover);
        int n, fetched, acked, t;
        logic [7:0] cnt;
        n = bytes.size();
        fetched = (nack_at < 0) ? n : nack_at;
        acked = (nack_at < 0) ? n : ((nack_at == 0) ? 0 : nack_at - 1);
        cnt = (acked > 255) ? 8'hFF : 8'(acked);
        exp_cmd_q.push_back({WR_START, 8'h00});
        exp_cmd_q.push_back({WR_DATA, addr, 1'b0});
        for (int i = 0; i < fetched; i++) exp_cmd_q.push_back({WR_DATA, bytes[i]});
        exp_cmd_q.push_back({WR_STOP, 8'h00});
        ack_plan_q.push_back(nack_at == 0);
        for (int i = 1; i <= fetched; i++) ack_plan_q.push_back(i == nack_at);
        exp_res = {(nack_at >= 0), cnt};
        exp_done_q.push_back(exp_res);
        for (int i = 0; i < n; i++) tx_q.push_back({(i == n - 1), bytes[i]});
        leftover = n - fetched;
        done_target = done_seen + 1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_addr = addr;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_addr = 7'($urandom_range(0, 127));
        chk("go_latency_0", {busy, wr_go}, 2'b10);
        @(negedge clock);
        chk("go_latency_1", {wr_go, wr_command}, {1'b1, WR_START});
    endtask

    task automatic wait_txn(input int leftover, input int budget);
        int t;
        t = 0;
        while (done_seen < done_target && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (done_seen < done_target) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
            finish_run();
        end
        repeat (3) @(negedge clock);
        chk("unfetched_bytes", tx_q.size(), leftover);
        chk("scoreboard_drained", exp_cmd_q.size() + ack_plan_q.size(), 0);
        chk("result_held", {nack_err, ack_count}, exp_res);
        flush_req++;
        repeat (2) @(negedge clock);
    endtask

    task automatic run_txn(input logic [6:0] addr, input logic [7:0] bytes[$], input int nack_at);
        int lo;
        start_txn(addr, bytes, nack_at, lo);
        wait_txn(lo, 400 + 80 * bytes.size());
    endtask

    initial begin : stimulus
        logic [7:0] bytes[$];
        int lo, base, t, bad, n, nack_at;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_outputs", outs(), 19'h40000);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_outputs", outs(), 19'h40000);

        bytes = '{8'hA5, 8'h3C};
        run_txn(7'h50, bytes, -1);

        bytes = '{8'h12, 8'h34};
        run_txn(7'h27, bytes, 0);

        bytes = '{8'h11, 8'h22, 8'h33};
        run_txn(7'h1C, bytes, 2);

        gate_hold = 1'b1;
        base = acks_done;
        bytes = '{8'h96, 8'h69};
        start_txn(7'h6B, bytes, -1, lo);
        t = 0;
        while (acks_done == base && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("addr_ack_seen", (acks_done != base), 1);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (wr_go || tx_ready || !busy) bad++;
        end
        chk("withheld_idle", bad, 0);
        gate_hold = 1'b0;
        wait_txn(lo, 600);

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(1, 6);
            bytes.delete();
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
            nack_at = ($urandom_range(0, 3) != 0) ? -1 : $urandom_range(0, n);
            run_txn(7'($urandom_range(0, 127)), bytes, nack_at);
        end

        bytes.delete();
        for (int i = 0; i < 300; i++) bytes.push_back(8'($urandom_range(0, 255)));
        run_txn(7'h7F, bytes, -1);

        inject_reset = 1'b1;
        base = reset_req;
        bytes = '{8'hC3, 8'h5A};
        start_txn(7'h3A, bytes, -1, lo);
        t = 0;
        while (reset_req == base && t < 400) begin
            @(negedge clock);
            t++;
        end
        chk("mid_data_reached", (reset_req != base), 1);
        chk("mid_data_state", {busy, wr_go, wr_command}, {2'b11, WR_DATA});
        reset = 1'b1;
        @(negedge clock);
        chk("reset_mid_data", outs(), 19'h40000);
        reset = 1'b0;
        exp_cmd_q.delete();
        exp_done_q.delete();
        ack_plan_q.delete();
        flush_req++;
        inject_reset = 1'b0;
        reset_ack = reset_req;
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (wr_go || busy || done) bad++;
        end
        chk("no_stop_after_reset", bad, 0);

        bytes = '{8'h00, 8'hFF, 8'h81};
        run_txn(7'h55, bytes, -1);

        finish_run();
    end

    initial begin : watchdog
        #900000;
        errors++;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        finish_run();
    end

endmodule
